fifo_read_handler: RTL and testbench

//  Read-side pointer/flag logic of the dual-clock FIFO; counterpart of the write handler.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/gray_to_bin.sv | 15 +
 rtl/fifo_read_handler.sv | 86 ++++++++
 tb/tb_fifo_read_handler.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer-encoding helpers for the dual-clock FIFO (read and write handlers).
// Functions operate on 32-bit words; callers zero-extend narrower pointers and
// truncate the result back to pointer width.
package fifo_pkg;

  localparam int CONV_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code to binary: each bit is the XOR of all Gray bits at or above it.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
    logic [CONV_W-1:0] bin;
    bin = '0;
    bin[CONV_W-1] = gray[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter of arbitrary width.
// Each output bit is the XOR-reduction of the Gray bits from itself up to the MSB,
// which keeps every bit independent (no ripple through the output vector).
module gray_to_bin #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_read_handler.sv
// Read-side pointer and flag logic of the dual-clock FIFO.
// Owns the binary read pointer (memory read address) and the Gray read pointer
// sent to the write domain. Brings the write domain's Gray pointer into clk through
// a plain flop chain and derives empty, almost_empty, fill_level and underflow.
// Flags are computed from the post-read pointer so the final entry's read sets
// empty on the same edge, and a freshly written entry only becomes visible once
// it has crossed the synchroniser (conservative: never falsely non-empty).
module fifo_read_handler
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH     = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [PTR_WIDTH:0]   wr_gray_ptr,
  input  logic                 rd_en,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 underflow,
  output logic [PTR_WIDTH:0]   fill_level,
  output logic [PTR_WIDTH:0]   bin_rd_ptr,
  output logic [PTR_WIDTH:0]   gray_rd_ptr
);

  localparam int PW1 = PTR_WIDTH + 1;

  (* ASYNC_REG = "TRUE" *) logic [PTR_WIDTH:0] sync_q [SYNC_STAGES];

  logic [PTR_WIDTH:0] wr_gray_sync;
  logic [PTR_WIDTH:0] wr_bin_sync;
  logic [PTR_WIDTH:0] rd_next;
  logic [PTR_WIDTH:0] gray_next;
  logic [PTR_WIDTH:0] level_next;
  logic               rd_accept;

  // First synchroniser stage captures the asynchronous Gray write pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q[0] <= '0;
    else       sync_q[0] <= wr_gray_ptr;
  end

  // Remaining synchroniser stages: straight flop-to-flop, no logic in between.
  for (genvar s = 1; s < SYNC_STAGES; s++) begin : g_sync
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q[s] <= '0;
      else       sync_q[s] <= sync_q[s-1];
    end
  end

  assign wr_gray_sync = sync_q[SYNC_STAGES-1];

  gray_to_bin #(.WIDTH(PW1)) u_wr_g2b (
    .gray (wr_gray_sync),
    .bin  (wr_bin_sync)
  );

  // Next-pointer and flag values; a read is only accepted against the registered empty.
  always_comb begin
    rd_accept  = rd_en & ~empty;
    rd_next    = bin_rd_ptr + {{PTR_WIDTH{1'b0}}, rd_accept};
    gray_next  = PW1'(bin2gray(CONV_W'(rd_next)));
    level_next = wr_bin_sync - rd_next;
  end

  // Pointer and flag registers, all updated on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_rd_ptr   <= '0;
      gray_rd_ptr  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      fill_level   <= '0;
      underflow    <= 1'b0;
    end else begin
      bin_rd_ptr   <= rd_next;
      gray_rd_ptr  <= gray_next;
      empty        <= (gray_next == wr_gray_sync);
      almost_empty <= (level_next <= PW1'(AEMPTY_THRESH));
      fill_level   <= level_next;
      underflow    <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_read_handler.sv
// Directed and randomised bench for fifo_read_handler with PTR_WIDTH=2,
// SYNC_STAGES=2, AEMPTY_THRESH=1. The bench plays the write domain directly by
// driving wr_gray_ptr synchronously to clk.
module tb_fifo_read_handler;

  localparam int PW = 2;

  logic          clk;
  logic          rstn;
  logic [PW:0]   wr_gray_ptr;
  logic          rd_en;
  logic          empty;
  logic          almost_empty;
  logic          underflow;
  logic [PW:0]   fill_level;
  logic [PW:0]   bin_rd_ptr;
  logic [PW:0]   gray_rd_ptr;

  int            checks;
  int            failures;
  logic [31:0]   exp_q[$];

  fifo_read_handler #(
    .PTR_WIDTH     (PW),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_gray_ptr  (wr_gray_ptr),
    .rd_en        (rd_en),
    .empty        (empty),
    .almost_empty (almost_empty),
    .underflow    (underflow),
    .fill_level   (fill_level),
    .bin_rd_ptr   (bin_rd_ptr),
    .gray_rd_ptr  (gray_rd_ptr)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW:0] to_gray(input int b);
    logic [PW:0] v;
    v = PW'(b) & 3'b111;
    v = 3'(b & 7);
    return v ^ (v >> 1);
  endfunction

  // Tests 1-5 and reset-mid-operation: hand-computed expectations.
  initial begin
    logic [PW:0] prev_ptr;
    logic [PW:0] prev_gray;
    int          w;
    int          delta;
    checks   = 0;
    failures = 0;
    rstn        = 1'b0;
    rd_en       = 1'b1;
    wr_gray_ptr = 3'b000;

    // 1: reset with rd_en high
    repeat (2) tick();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_aempty", {31'd0, almost_empty}, 32'd1);
    check("rst_bin", {29'd0, bin_rd_ptr}, 32'd0);
    check("rst_gray", {29'd0, gray_rd_ptr}, 32'd0);
    check("rst_fill", {29'd0, fill_level}, 32'd0);
    check("rst_uflow", {31'd0, underflow}, 32'd0);
    rd_en = 1'b0;
    rstn  = 1'b1;
    tick();

    // 2: sync latency, one write appears after exactly 3 edges
    wr_gray_ptr = 3'b001;
    tick();
    check("lat_e1_empty", {31'd0, empty}, 32'd1);
    tick();
    check("lat_e2_empty", {31'd0, empty}, 32'd1);
    tick();
    check("lat_e3_empty", {31'd0, empty}, 32'd0);
    check("lat_fill", {29'd0, fill_level}, 32'd1);
    check("lat_aempty", {31'd0, almost_empty}, 32'd1);

    // 3: full FIFO (write bin 4) then drain with rd_en held 4 cycles
    wr_gray_ptr = 3'b110;
    repeat (3) tick();
    check("full_fill", {29'd0, fill_level}, 32'd4);
    check("full_aempty", {31'd0, almost_empty}, 32'd0);
    check("full_bin", {29'd0, bin_rd_ptr}, 32'd0);
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_bin", {29'd0, bin_rd_ptr}, 32'(i));
      check("drain_fill", {29'd0, fill_level}, 32'(4 - i));
      check("drain_empty", {31'd0, empty}, (i == 4) ? 32'd1 : 32'd0);
      check("drain_aempty", {31'd0, almost_empty}, (i >= 3) ? 32'd1 : 32'd0);
    end

    // 4: underflow, rd_en still high for one more cycle while empty
    tick();
    check("uflow_pulse", {31'd0, underflow}, 32'd1);
    check("uflow_bin", {29'd0, bin_rd_ptr}, 32'd4);
    rd_en = 1'b0;
    tick();
    check("uflow_drop", {31'd0, underflow}, 32'd0);
    check("uflow_bin2", {29'd0, bin_rd_ptr}, 32'd4);

    // 5: 12 write/read pairs, pointer wraps 7 -> 0
    w = 4;
    for (int i = 1; i <= 12; i++) begin
      w++;
      wr_gray_ptr = to_gray(w);
      repeat (3) tick();
      check("wrap_ne", {31'd0, empty}, 32'd0);
      check("wrap_fill1", {29'd0, fill_level}, 32'd1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("wrap_bin", {29'd0, bin_rd_ptr}, 32'((4 + i) & 7));
      check("wrap_gray", {29'd0, gray_rd_ptr}, {29'd0, to_gray(4 + i)});
      check("wrap_empty", {31'd0, empty}, 32'd1);
      check("wrap_fill0", {29'd0, fill_level}, 32'd0);
    end
    check("wrap_end_gray", {29'd0, gray_rd_ptr}, 32'd0);

    // 6: random reads and writes; write side respects the DUT's Gray read pointer
    for (int c = 0; c < 10000; c++) begin
      rd_en = 1'($urandom_range(0, 1));
      if ((((w & 7) - int'(fifo_pkg::gray2bin(32'(gray_rd_ptr)))) & 7) < 4 &&
          $urandom_range(0, 1) == 1) begin
        exp_q.push_back(32'(w & 7));
        w++;
        wr_gray_ptr = to_gray(w);
      end
      prev_ptr  = bin_rd_ptr;
      prev_gray = gray_rd_ptr;
      tick();
      check("rnd_gray_ham", {31'd0, $countones(prev_gray ^ gray_rd_ptr) <= 1}, 32'd1);
      delta = int'(bin_rd_ptr - prev_ptr) & 7;
      check("rnd_step", {31'd0, delta <= 1}, 32'd1);
      check("rnd_no_pass", {31'd0, ((((w & 7) - int'(bin_rd_ptr)) & 7) <= 4)}, 32'd1);
      if (delta == 1) begin
        if (exp_q.size() == 0) begin
          check("rnd_sb_empty", 32'd1, 32'd0);
        end else begin
          check("rnd_sb_addr", {29'd0, prev_ptr}, exp_q.pop_front());
        end
      end
    end

    // Reset mid-operation takes effect without a clock edge
    rd_en = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    check("mid_rst_bin", {29'd0, bin_rd_ptr}, 32'd0);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_fill", {29'd0, fill_level}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
